// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: phase-accumulator front end for the iterative CORDIC core.
// Holds a 16-bit full-circle phase. Each issued sample carries two fields:
//   - angle: the phase folded to a first-quadrant Q2.6 angle (0..100).
//   - quadrant: the 2-bit tag phase[15:14].
// Samples are paced so that at least ISSUE_PERIOD cycles pass between an
// issue (or acceptance) and the next angle_valid.
// Optional feature: define CORDIC_PHASE_DITHER_EN to add 6-bit LFSR dither
// to the fraction before scaling. With the macro undefined, no LFSR exists.
//
// Handshake: a sample transfers on a rising edge where angle_valid and
// angle_ready are both high. Once angle_valid rises, angle, quadrant and
// angle_valid stay constant until that transfer, whatever enable or load do.
// angle_ready never reaches an output combinationally.
module cordic_phase_gen #(
  parameter int ISSUE_PERIOD = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] phase_init,
  input  logic [15:0] freq_word,
  output logic [7:0]  angle,
  output logic [1:0]  quadrant,
  output logic        angle_valid,
  input  logic        angle_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COUNT   = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  localparam logic [7:0] CNT_RELOAD = 8'(ISSUE_PERIOD - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [15:0] phase;
  logic [13:0] frac;
  logic [7:0]  angle_next;
  logic        accept;

  assign accept = angle_valid && angle_ready;

`ifdef CORDIC_PHASE_DITHER_EN
  logic [7:0]  lfsr;
  logic [14:0] frac_sum;

  // Dithered fraction, saturated at the top of the quadrant
  always_comb begin
    frac_sum = {1'b0, phase[13:0]} + {9'd0, lfsr[5:0]};
    frac     = frac_sum[14] ? 14'h3FFF : frac_sum[13:0];
  end

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, advanced once per accepted sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end
`else
  assign frac = phase[13:0];
`endif

  // Scale the 14-bit fraction to Q2.6 radians: (f * 201) >> 15, max 100
  assign angle_next = 8'(({8'd0, frac} * 22'd201) >> 15);

  assign busy = (state != S_IDLE);

  // Issue pacing FSM, phase accumulator and registered sample outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      phase       <= 16'd0;
      angle       <= 8'd0;
      quadrant    <= 2'd0;
      angle_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load) begin
            phase <= phase_init;
          end
          if (enable) begin
            state <= S_COUNT;
            cnt   <= CNT_RELOAD;
          end
        end
        S_COUNT: begin
          // A load at the issuing edge lands in the accumulator; the
          // sample itself is taken from the phase held before the edge.
          if (load) begin
            phase <= phase_init;
          end
          if (!enable) begin
            state <= S_IDLE;
          end else if (cnt == 8'd0) begin
            state       <= S_PRESENT;
            angle       <= angle_next;
            quadrant    <= phase[15:14];
            angle_valid <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_PRESENT: begin
          if (accept) begin
            phase       <= phase + freq_word;
            angle_valid <= 1'b0;
            if (enable) begin
              state <= S_COUNT;
              cnt   <= CNT_RELOAD;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          angle_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cordic_phase_gen.md
# cordic_phase_gen

Phase-accumulator front end for the CORDIC sine/cosine core. It holds a 16-bit full-circle phase and folds it into a first-quadrant angle in the core's 8-bit Q2.6 radian format, with a 2-bit quadrant tag alongside. Each sample is issued over a valid/ready handshake, paced so the iterative core has finished one conversion before the next angle arrives. The phase advances once per accepted sample, giving a sample-indexed NCO. The quadrant tag travels with the sample so the downstream stage can restore the sign and swap of sin/cos.

## Interface
- `ISSUE_PERIOD`, 12: minimum number of cycles from an issue or acceptance to the next `angle_valid`. Legal range is 2..255.
- `clk`  input  1: the single clock. All state changes on the rising edge.
- `rst`  input  1: reset, asynchronous and active-high.
- `enable`  input  1: run request. While high, samples are generated.
- `load`  input  1: load request. Writes `phase_init` into the phase accumulator.
- `phase_init`  input  16: value loaded into the phase accumulator on `load`.
- `freq_word`  input  16: phase increment applied per accepted sample. Full circle is 2^16.
- `angle`  output  8: first-quadrant angle, Q2.6 radians, range 0..100 (100 ≈ π/2).
- `quadrant`  output  2: quadrant tag, equal to `phase[15:14]` of the issued sample.
- `angle_valid`  output  1: `angle` and `quadrant` hold a valid sample.
- `angle_ready`  input  1: the consumer accepts the sample.
- `busy`  output  1: high whenever the state is not IDLE.

## Operation
- Phase accumulator: `phase[15:0]`, unsigned, wraps modulo 2^16.
- Fraction `f = phase[13:0]`.
- Angle scaling: `angle = (f * 201) >> 15`.
  - The product is 22 bits wide.
  - `angle` is the truncated result, maximum 100 at f = 0x3FFF.
- Quadrant tag: `quadrant = phase[15:14]`. No mirroring is applied. The downstream correction is:
  - q0: sin = s, cos = c.
  - q1: sin = c, cos = −s.
  - q2: sin = −s, cos = −c.
  - q3: sin = −c, cos = s.
- State IDLE:
  - `enable` = 1 → go to COUNT with `cnt = ISSUE_PERIOD-1`.
- State COUNT:
  - `enable` = 0 → go to IDLE. The pending count is discarded.
  - `cnt` = 0 → go to PRESENT. `angle` and `quadrant` are registered from the current `phase`, and `angle_valid` is set to 1.
  - Otherwise, `cnt` decrements.
- State PRESENT:
  - `angle`, `quadrant` and `angle_valid` are held stable until `angle_valid && angle_ready`.
  - On acceptance:
    - `phase <= phase + freq_word`.
    - `angle_valid` is set to 0.
    - Next state is COUNT with `cnt = ISSUE_PERIOD-1` if `enable` = 1, otherwise IDLE.
  - Deasserting `enable` never drops a presented sample.
- `load`:
  - Honoured in IDLE and COUNT. It does not change state or `cnt`.
  - Ignored while `angle_valid` = 1.
  - `load` together with `enable` in IDLE: both take effect in the same cycle.
- Reset values:
  - `phase` = 0, `cnt` = 0, state = IDLE.
  - `angle` = 0, `quadrant` = 0, `angle_valid` = 0, `busy` = 0.
  - Reset mid-operation aborts immediately. No sample is completed.

## Timing
- Outputs are registered. There is no combinational path from `angle_ready` to any output.
- `enable` sampled high in IDLE at edge k → `angle_valid` rises at edge k+ISSUE_PERIOD.
- Acceptance at edge m, with `enable` held high → next `angle_valid` at edge m+ISSUE_PERIOD.
- `angle_ready` held permanently high → one sample every ISSUE_PERIOD+1 cycles.
- A phase update from acceptance is visible in the next issued sample.
- A `load` at edge j takes effect at edge j and is visible in any sample issued at j+1 or later.

## Configuration
- `CORDIC_PHASE_DITHER_EN` defined:
  - An 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, is added to the design.
  - The LFSR resets to 8'hA5 and steps once per acceptance.
  - At issue, the fraction becomes `f' = min(f + lfsr[5:0], 0x3FFF)` before scaling.
- Macro undefined:
  - No LFSR is instantiated and `f` is used directly.
  - The block is bit-exact to the Operation section.

## Test plan
- Quadrant cycle: `phase_init` = 0, `freq_word` = 0x4000, `enable` = 1, `angle_ready` = 1 → quadrant 0,1,2,3,0 with `angle` = 0 each time, samples spaced 13 cycles apart.
- Scaling: load 0x2000, then 0x3FFF, with `freq_word` = 0 → `angle` = 50 then 100, quadrant 0; load 0x7FFF → `angle` = 100, quadrant 1.
- Backpressure: hold `angle_ready` = 0 for 5 cycles during PRESENT → `angle`, `quadrant` and `angle_valid` are unchanged; raise `angle_ready` → sample accepted, next valid 12 cycles later.
- Wrap: `phase_init` = 0xFFF0, `freq_word` = 0x0020 → second sample has phase 0x0010, quadrant 0, `angle` = 0.
- Enable/load corners: drop `enable` mid-COUNT → IDLE with no valid; drop `enable` in PRESENT → sample kept until accepted, then IDLE; pulse `load` during PRESENT → ignored.
- Reset mid-PRESENT: assert `rst` asynchronously → all outputs 0 immediately; after release with `enable` = 1, the first valid occurs ISSUE_PERIOD cycles after the first sampled edge.
